// File: rtl/sw_io_pkg.sv
// Shared types and defaults for the switch input conditioning path.
package sw_io_pkg;

    localparam int unsigned SW_WIDTH          = 16;
    localparam int unsigned SW_STABLE_DEFAULT = 50000;
    localparam int unsigned SW_CNT_W          = 16;

    typedef logic [SW_WIDTH-1:0] sw_vec_t;

    // True when a stability threshold fits a counter of the given width without wrapping.
    function automatic bit stable_cycles_ok(input int unsigned stable, input int unsigned cnt_w);
        longint unsigned max_val;
        max_val = (64'(1) << cnt_w) - 64'(1);
        return (stable >= 1) && (64'(stable) <= max_val);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level and edge strobes.
module sw_debounce_bit
    import sw_io_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = SW_STABLE_DEFAULT,
    parameter int unsigned CNT_W         = SW_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic rise_c,
    output logic fall_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dout_nxt;

    // Accept s2 only after it has differed from dout for STABLE_CYCLES consecutive edges.
    always_comb begin
        cnt_nxt  = '0;
        dout_nxt = dout;
        rise_c   = 1'b0;
        fall_c   = 1'b0;
        if (s2 != dout) begin
            if (cnt == CNT_LAST) begin
                dout_nxt = s2;
                rise_c   = s2;
                fall_c   = ~s2;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            cnt  <= cnt_nxt;
            dout <= dout_nxt;
            rise <= rise_c;
            fall <= fall_c;
        end
    end

endmodule

// File: rtl/sw_debouncer.sv
// Debounced slide-switch front end with sticky event flags and IRQ summary.
// Build option: SW_DEBOUNCE_BOTH_EDGES_EN makes falling edges set EVT_PEND as well.
module sw_debouncer
    import sw_io_pkg::*;
#(
    parameter int unsigned WIDTH         = SW_WIDTH,
    parameter int unsigned STABLE_CYCLES = SW_STABLE_DEFAULT,
    parameter int unsigned CNT_W         = SW_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN_SW,
    input  logic [WIDTH-1:0] EVT_CLR,
    output logic [WIDTH-1:0] DOUT_SW,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic [WIDTH-1:0] EVT_PEND,
    output logic             IRQ
);

    if (!stable_cycles_ok(STABLE_CYCLES, CNT_W)) begin : g_param_check
        $error("sw_debouncer: STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

`ifdef SW_DEBOUNCE_BOTH_EDGES_EN
    localparam bit FALL_SETS_PEND = 1'b1;
`else
    localparam bit FALL_SETS_PEND = 1'b0;
`endif

    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] evt_set_c;
    logic [WIDTH-1:0] pend_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk    (CLK),
            .rst    (RST),
            .din    (DIN_SW[i]),
            .dout   (DOUT_SW[i]),
            .rise   (RISE[i]),
            .fall   (FALL[i]),
            .rise_c (rise_c[i]),
            .fall_c (fall_c[i])
        );
    end

    // Pending flags track the strobes on the same edge; a set beats a simultaneous clear.
    always_comb begin
        evt_set_c = rise_c | (fall_c & {WIDTH{FALL_SETS_PEND}});
        pend_nxt  = (EVT_PEND & ~EVT_CLR) | evt_set_c;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVT_PEND <= '0;
        end else begin
            EVT_PEND <= pend_nxt;
        end
    end

    assign IRQ = |EVT_PEND;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer (STABLE_CYCLES=4); expectations queued per edge, checked by a monitor.
module tb_sw_debouncer;
    import sw_io_pkg::*;

    localparam int unsigned STABLE = 4;

`ifdef SW_DEBOUNCE_BOTH_EDGES_EN
    localparam bit BOTH_EDGES = 1'b1;
`else
    localparam bit BOTH_EDGES = 1'b0;
`endif

    localparam sw_vec_t ALL      = 16'hFFFF;
    localparam sw_vec_t FALL_PND = BOTH_EDGES ? 16'hFFFF : 16'h0000;
    localparam sw_vec_t B7_PND   = BOTH_EDGES ? 16'h0080 : 16'h0000;
    localparam sw_vec_t IRQ_BOTH = BOTH_EDGES ? 16'h0001 : 16'h0000;

    logic    clk = 1'b0;
    logic    rst;
    sw_vec_t din_sw;
    sw_vec_t evt_clr;
    sw_vec_t dout_sw;
    sw_vec_t rise;
    sw_vec_t fall;
    sw_vec_t evt_pend;
    logic    irq;

    sw_debouncer #(
        .WIDTH         (SW_WIDTH),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (SW_CNT_W)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .DIN_SW   (din_sw),
        .EVT_CLR  (evt_clr),
        .DOUT_SW  (dout_sw),
        .RISE     (rise),
        .FALL     (fall),
        .EVT_PEND (evt_pend),
        .IRQ      (irq)
    );

    always #5 clk = ~clk;

    typedef enum {F_DOUT, F_RISE, F_FALL, F_PEND, F_IRQ} field_e;

    typedef struct {
        int      cyc;
        field_e  fld;
        sw_vec_t mask;
        sw_vec_t val;
        string   name;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      edge_n = 0;
    sw_vec_t act;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic sw_vec_t pick(input field_e f);
        case (f)
            F_DOUT:  return dout_sw;
            F_RISE:  return rise;
            F_FALL:  return fall;
            F_PEND:  return evt_pend;
            F_IRQ:   return sw_vec_t'(irq);
            default: return '0;
        endcase
    endfunction

    task automatic exp_at(input int cyc, input field_e f, input sw_vec_t mask,
                          input sw_vec_t val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.fld  = f;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation that falls due on this edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_n) begin
                act = pick(sb[i].fld);
                checks++;
                if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    errors++;
                    $display("FAIL %s @edge %0d: got %h want %h (mask %h)",
                             sb[i].name, edge_n, act & sb[i].mask,
                             sb[i].val & sb[i].mask, sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_pend(input sw_vec_t bits, input string name);
        evt_clr = bits;
        exp_at(edge_n + 1, F_PEND, bits, 16'h0000, name);
        step(1);
        evt_clr = '0;
    endtask

    int e;

    initial begin
        rst     = 1'b1;
        din_sw  = ALL;
        evt_clr = '0;

        // Reset held with all switches high: everything stays at 0.
        for (int k = 1; k <= 3; k++) begin
            exp_at(k, F_DOUT, ALL, 16'h0000, "rst_dout");
            exp_at(k, F_RISE, ALL, 16'h0000, "rst_rise");
            exp_at(k, F_PEND, ALL, 16'h0000, "rst_pend");
            exp_at(k, F_IRQ,  ALL, 16'h0000, "rst_irq");
        end
        step(3);
        rst = 1'b0;
        e   = edge_n;
        exp_at(e + 5, F_DOUT, ALL, 16'h0000, "rel_dout_early");
        exp_at(e + 6, F_DOUT, ALL, 16'hFFFF, "rel_dout");
        exp_at(e + 6, F_RISE, ALL, 16'hFFFF, "rel_rise");
        exp_at(e + 6, F_PEND, ALL, 16'hFFFF, "rel_pend");
        exp_at(e + 6, F_IRQ,  ALL, 16'h0001, "rel_irq");
        exp_at(e + 7, F_RISE, ALL, 16'h0000, "rel_rise_end");
        step(8);
        checks++;
        if (dout_sw !== ALL) begin
            errors++;
            $display("FAIL rel_settled_dout: got %h", dout_sw);
        end
        checks++;
        if (evt_pend !== ALL) begin
            errors++;
            $display("FAIL rel_settled_pend: got %h", evt_pend);
        end

        // Clear everything and drop every switch: global fall.
        din_sw  = '0;
        evt_clr = ALL;
        e       = edge_n;
        exp_at(e + 1, F_PEND, ALL, 16'h0000, "clr_all_pend");
        exp_at(e + 1, F_IRQ,  ALL, 16'h0000, "clr_all_irq");
        step(1);
        evt_clr = '0;
        exp_at(e + 5, F_DOUT, ALL, 16'hFFFF, "fall_dout_early");
        exp_at(e + 6, F_DOUT, ALL, 16'h0000, "fall_dout");
        exp_at(e + 6, F_FALL, ALL, 16'hFFFF, "fall_strobe");
        exp_at(e + 6, F_RISE, ALL, 16'h0000, "fall_no_rise");
        exp_at(e + 6, F_PEND, ALL, FALL_PND, "fall_pend");
        exp_at(e + 6, F_IRQ,  ALL, IRQ_BOTH, "fall_irq");
        exp_at(e + 7, F_FALL, ALL, 16'h0000, "fall_strobe_end");
        step(7);
        clear_pend(ALL, "fall_pend_clr");

        // Clean rise on bit 0, then write-1-to-clear.
        din_sw = 16'h0001;
        e      = edge_n;
        exp_at(e + 5, F_DOUT, ALL, 16'h0000, "b0_dout_early");
        exp_at(e + 6, F_DOUT, ALL, 16'h0001, "b0_dout");
        exp_at(e + 6, F_RISE, ALL, 16'h0001, "b0_rise");
        exp_at(e + 6, F_PEND, ALL, 16'h0001, "b0_pend");
        exp_at(e + 6, F_IRQ,  ALL, 16'h0001, "b0_irq");
        exp_at(e + 7, F_RISE, ALL, 16'h0000, "b0_rise_end");
        exp_at(e + 7, F_PEND, ALL, 16'h0001, "b0_pend_sticky");
        step(8);
        exp_at(edge_n + 1, F_IRQ,  ALL, 16'h0000, "b0_clr_irq");
        exp_at(edge_n + 1, F_DOUT, ALL, 16'h0001, "b0_clr_dout");
        clear_pend(16'h0001, "b0_clr_pend");
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL b0_clr_irq_direct: got %b", irq);
        end

        // Bounce on bit 3: each level held 3 cycles, one short of the threshold.
        e = edge_n;
        for (int k = 1; k <= 16; k++) begin
            exp_at(e + k, F_DOUT, ALL, 16'h0001, "bounce_dout");
            exp_at(e + k, F_RISE, ALL, 16'h0000, "bounce_rise");
            exp_at(e + k, F_FALL, ALL, 16'h0000, "bounce_fall");
            exp_at(e + k, F_PEND, ALL, 16'h0000, "bounce_pend");
        end
        din_sw = 16'h0009;
        step(3);
        din_sw = 16'h0001;
        step(3);
        din_sw = 16'h0009;
        step(3);
        din_sw = 16'h0001;
        step(8);
        checks++;
        if (dout_sw !== 16'h0001) begin
            errors++;
            $display("FAIL bounce_dout_direct: got %h", dout_sw);
        end

        // Set/clear collision on bit 5 with clear held high.
        evt_clr = 16'h0020;
        din_sw  = 16'h0021;
        e       = edge_n;
        exp_at(e + 6, F_RISE, ALL,      16'h0020, "col_rise");
        exp_at(e + 6, F_PEND, 16'h0020, 16'h0020, "col_pend_set");
        exp_at(e + 6, F_IRQ,  ALL,      16'h0001, "col_irq");
        exp_at(e + 7, F_PEND, 16'h0020, 16'h0000, "col_pend_clr");
        exp_at(e + 7, F_IRQ,  ALL,      16'h0000, "col_irq_clr");
        step(8);
        evt_clr = '0;

        // Bit 7: rise, clear, then fall.
        din_sw = 16'h00A1;
        e      = edge_n;
        exp_at(e + 6, F_RISE, ALL,      16'h0080, "b7_rise");
        exp_at(e + 6, F_PEND, 16'h0080, 16'h0080, "b7_rise_pend");
        step(8);
        clear_pend(16'h0080, "b7_pend_clr");
        din_sw = 16'h0021;
        e      = edge_n;
        exp_at(e + 5, F_DOUT, ALL,      16'h00A1, "b7_dout_early");
        exp_at(e + 6, F_DOUT, ALL,      16'h0021, "b7_dout_fall");
        exp_at(e + 6, F_FALL, ALL,      16'h0080, "b7_fall");
        exp_at(e + 6, F_PEND, ALL,      B7_PND,   "b7_fall_pend");
        exp_at(e + 6, F_IRQ,  ALL,      IRQ_BOTH, "b7_fall_irq");
        exp_at(e + 7, F_FALL, ALL,      16'h0000, "b7_fall_end");
        step(8);
        clear_pend(ALL, "b7_final_clr");

        // Reset in the middle of a bit-2 count discards the progress.
        din_sw = 16'h0025;
        e      = edge_n;
        step(3);
        rst = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            exp_at(e + k, F_DOUT, ALL, 16'h0000, "mid_rst_dout");
            exp_at(e + k, F_PEND, ALL, 16'h0000, "mid_rst_pend");
            exp_at(e + k, F_IRQ,  ALL, 16'h0000, "mid_rst_irq");
        end
        step(2);
        rst = 1'b0;
        e   = edge_n;
        exp_at(e + 5, F_DOUT, ALL, 16'h0000, "mid_rel_dout_early");
        exp_at(e + 6, F_DOUT, ALL, 16'h0025, "mid_rel_dout");
        exp_at(e + 6, F_RISE, ALL, 16'h0025, "mid_rel_rise");
        exp_at(e + 6, F_PEND, ALL, 16'h0025, "mid_rel_pend");
        exp_at(e + 6, F_IRQ,  ALL, 16'h0001, "mid_rel_irq");
        step(10);
        checks++;
        if (dout_sw !== 16'h0025) begin
            errors++;
            $display("FAIL mid_rel_dout_direct: got %h", dout_sw);
        end

        // Any expectation left over was never reached.
        foreach (sb[i]) begin
            errors++;
            $display("FAIL %s: never checked, due edge %0d, now %0d", sb[i].name, sb[i].cyc, edge_n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Input conditioning stage between the board slide switches and the GPIO peripheral's switch input.
- Synchronises each raw switch bit and debounces it with a per-bit stability counter.
- Produces clean levels, single-cycle rise/fall strobes, and sticky pending-event flags with an interrupt summary.
- The GPIO block consumes DOUT_SW in place of the raw pins.

Parameters:
- WIDTH, 16, number of switch bits.
- STABLE_CYCLES, 50000, consecutive cycles a synchronised bit must hold a new value before it is accepted (1 ms at 50 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 16, width of each per-bit stability counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high; one clock, no other clock domains.
- DIN_SW  input  WIDTH  raw asynchronous switch pins.
- EVT_CLR  input  WIDTH  write-1-to-clear strobe for EVT_PEND bits; sampled each cycle.
- DOUT_SW  output  WIDTH  debounced switch levels.
- RISE  output  WIDTH  one-cycle pulse when a debounced bit goes 0->1.
- FALL  output  WIDTH  one-cycle pulse when a debounced bit goes 1->0.
- EVT_PEND  output  WIDTH  sticky event flags.
- IRQ  output  1  OR-reduction of EVT_PEND.

Behaviour:
Reset (asynchronous, RST=1):
- Sync flops, counters, DOUT_SW, RISE, FALL and EVT_PEND all clear to 0.
- IRQ is therefore 0.
- Reset mid-count discards progress; after release every bit restarts from 0.

Synchronisation:
- Two-flop synchroniser per bit, s1 then s2.

Debounce (per bit, evaluated every rising edge):
- s2 == DOUT_SW[i]: counter <= 0.
- s2 != DOUT_SW[i] and counter == STABLE_CYCLES-1: DOUT_SW[i] <= s2; counter <= 0; the matching RISE[i] or FALL[i] is 1 on that same edge.
- s2 != DOUT_SW[i] otherwise: counter <= counter+1.
- RISE and FALL are registered and high for exactly one cycle, coincident with the first cycle of the new DOUT_SW value.
- A bounce shorter than STABLE_CYCLES resets the counter, so DOUT_SW does not change and no strobe fires.

Latency:
- If the raw input changes and stays stable, DOUT_SW changes STABLE_CYCLES+2 rising edges after the edge that first samples the new value into s1.
- STABLE_CYCLES=1 gives a latency of 3 edges.

Events:
- EVT_PEND[i] is set on RISE[i]; see Optional Feature for FALL.
- EVT_PEND[i] is cleared when EVT_CLR[i]=1.
- Set and clear on the same edge: set wins, so no event is lost.
- Clear of an already-clear bit has no effect.
- IRQ is combinational OR of EVT_PEND; it has no extra latency.

Independence and counter width:
- Bits are fully independent; simultaneous transitions on several bits produce simultaneous strobes.
- Counter never wraps: it is bounded by STABLE_CYCLES-1.
- Elaboration error if STABLE_CYCLES < 1 or STABLE_CYCLES > 2^CNT_W-1.

Optional Feature:
- Macro: SW_DEBOUNCE_BOTH_EDGES_EN.
- Defined: EVT_PEND[i] is set on RISE[i] or FALL[i].
- Undefined: EVT_PEND[i] is set on RISE[i] only; FALL still pulses but never sets pending.
- DOUT_SW, RISE and FALL timing are identical in both builds.

Decomposition:
- Package sw_io_pkg:
  - SW_WIDTH=16.
  - SW_STABLE_DEFAULT=50000.
  - SW_CNT_W=16.
  - typedef logic [SW_WIDTH-1:0] sw_vec_t.
- Sub-module sw_debounce_bit:
  - Contains the synchroniser, stability counter, debounced level, and RISE/FALL for one bit.
  - Instantiated WIDTH times via generate.
- Top level holds only EVT_PEND and IRQ.

Test Plan (bench uses STABLE_CYCLES=4, WIDTH=16):
- Reset: assert RST with DIN_SW=16'hFFFF -> all outputs 0 while RST=1. Release -> DOUT_SW=16'hFFFF on the 6th edge; RISE=16'hFFFF for that single cycle; EVT_PEND=16'hFFFF; IRQ=1.
- Clean edge: DIN_SW[0] 0->1 and held -> DOUT_SW[0]=1 after 6 edges; RISE[0] high exactly 1 cycle; EVT_PEND[0]=1. Then set EVT_CLR[0]=1 for one cycle -> EVT_PEND[0]=0, IRQ=0.
- Bounce rejection: DIN_SW[3] toggles 1,0,1,0 with each level held 3 cycles, then stays 0 -> DOUT_SW[3] stays 0; no RISE/FALL; EVT_PEND unchanged.
- Set/clear collision: hold EVT_CLR[5]=1 continuously while a debounced rise on bit 5 occurs -> EVT_PEND[5]=1 on the strobe cycle, then 0 on the next cycle.
- Falling edge, both builds: DOUT_SW[7]=1, then DIN_SW[7] goes to 0 -> FALL[7] pulses 1 cycle. With SW_DEBOUNCE_BOTH_EDGES_EN, EVT_PEND[7]=1; without it, EVT_PEND[7] stays 0.
- Reset mid-count: DIN_SW[2] rises; assert RST 3 edges later; release with DIN_SW[2]=1 -> DOUT_SW[2]=0 until 6 full edges after release, then 1.
